// File: rtl/exp5_pkg.sv
// Shared definitions for the Experiment 5 sequence-memory game: state codes
// (also used by the hex display decoder) and default timing/round limits.
package exp5_pkg;

  typedef enum logic [3:0] {
    INICIAL        = 4'd0,
    PREPARACAO     = 4'd1,
    INICIA_RODADA  = 4'd2,
    ESPERA_JOGADA  = 4'd3,
    REGISTRA       = 4'd4,
    COMPARACAO     = 4'd5,
    PROXIMA_JOGADA = 4'd6,
    PROXIMA_RODADA = 4'd7,
    FIM_ACERTOU    = 4'd10,
    FIM_TIMEOUT    = 4'd13,
    FIM_ERROU      = 4'd14
  } estado_t;

  localparam int TIMEOUT_CICLOS_PADRAO = 5000;
  localparam int RODADAS_MODO1_PADRAO  = 4;
  localparam int RODADAS_MODO0_PADRAO  = 16;

  // 0-based index of the final round, truncated to the 4-bit round counter
  function automatic logic [3:0] ultima_rodada(input int rodadas);
    return 4'(rodadas - 1);
  endfunction

endpackage

// File: rtl/exp5_contador_timeout.sv
// Saturating play-timeout counter; fim rises once TIMEOUT_CICLOS-1 is reached
// and stays there until zera clears it.
module exp5_contador_timeout
  import exp5_pkg::*;
#(
  parameter int TIMEOUT_CICLOS = TIMEOUT_CICLOS_PADRAO
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim
);

  localparam int W = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
  localparam logic [W-1:0] ULTIMO = W'(TIMEOUT_CICLOS - 1);

  logic [W-1:0] contagem;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      contagem <= '0;
    end else if (zera) begin
      contagem <= '0;
    end else if (conta && (contagem != ULTIMO)) begin
      contagem <= contagem + W'(1);
    end
  end

  assign fim = (contagem == ULTIMO);

endmodule

// File: rtl/exp5_unidade_controle.sv
// Moore control FSM for the Experiment 5 game: sequences the play/round
// counters, play register, comparison and play timeout.
module exp5_unidade_controle
  import exp5_pkg::*;
#(
  parameter int TIMEOUT_CICLOS = TIMEOUT_CICLOS_PADRAO,
  parameter int RODADAS_MODO1  = RODADAS_MODO1_PADRAO,
  parameter int RODADAS_MODO0  = RODADAS_MODO0_PADRAO
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       modo,
  input  logic       jogada,
  input  logic       igual,
  input  logic       fimC,
  input  logic [3:0] rodada,
  output logic       zeraC,
  output logic       contaC,
  output logic       zeraCL,
  output logic       contaCL,
  output logic       zeraR,
  output logic       registraR,
  output logic       acertou,
  output logic       errou,
  output logic       pronto,
  output logic       db_timeout,
  output logic [3:0] db_estado
);

  localparam logic [3:0] ULTIMA_MODO1 = ultima_rodada(RODADAS_MODO1);
  localparam logic [3:0] ULTIMA_MODO0 = ultima_rodada(RODADAS_MODO0);

  estado_t estado, estado_prox;
  logic    modo_r;
  logic    fim_timeout;
  logic    ultima;

  // Leaving ESPERA_JOGADA for any other state restarts the timeout window
  exp5_contador_timeout #(
    .TIMEOUT_CICLOS(TIMEOUT_CICLOS)
  ) u_timeout (
    .clock(clock),
    .reset(reset),
    .zera (estado != ESPERA_JOGADA),
    .conta(estado == ESPERA_JOGADA),
    .fim  (fim_timeout)
  );

  assign ultima = (rodada == (modo_r ? ULTIMA_MODO1 : ULTIMA_MODO0));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado <= INICIAL;
      modo_r <= 1'b0;
    end else begin
      estado <= estado_prox;
      if (estado == PREPARACAO) begin
        modo_r <= modo;
      end
    end
  end

  always_comb begin
    estado_prox = estado;
    zeraC       = 1'b0;
    contaC      = 1'b0;
    zeraCL      = 1'b0;
    contaCL     = 1'b0;
    zeraR       = 1'b0;
    registraR   = 1'b0;
    acertou     = 1'b0;
    errou       = 1'b0;
    pronto      = 1'b0;
    db_timeout  = 1'b0;
    case (estado)
      INICIAL: begin
        if (iniciar) estado_prox = PREPARACAO;
      end
      PREPARACAO: begin
        zeraCL      = 1'b1;
        zeraC       = 1'b1;
        zeraR       = 1'b1;
        estado_prox = INICIA_RODADA;
      end
      INICIA_RODADA: begin
        zeraC       = 1'b1;
        estado_prox = ESPERA_JOGADA;
      end
      // A play on the last allowed cycle still counts
      ESPERA_JOGADA: begin
        if (jogada)           estado_prox = REGISTRA;
        else if (fim_timeout) estado_prox = FIM_TIMEOUT;
      end
      REGISTRA: begin
        registraR   = 1'b1;
        estado_prox = COMPARACAO;
      end
      COMPARACAO: begin
        if (!igual)      estado_prox = FIM_ERROU;
        else if (!fimC)  estado_prox = PROXIMA_JOGADA;
        else if (ultima) estado_prox = FIM_ACERTOU;
        else             estado_prox = PROXIMA_RODADA;
      end
      PROXIMA_JOGADA: begin
        contaC      = 1'b1;
        estado_prox = ESPERA_JOGADA;
      end
      PROXIMA_RODADA: begin
        contaCL     = 1'b1;
        estado_prox = INICIA_RODADA;
      end
      FIM_ACERTOU: begin
        acertou = 1'b1;
        pronto  = 1'b1;
        if (iniciar) estado_prox = PREPARACAO;
      end
      FIM_ERROU: begin
        errou  = 1'b1;
        pronto = 1'b1;
        if (iniciar) estado_prox = PREPARACAO;
      end
      FIM_TIMEOUT: begin
        errou      = 1'b1;
        pronto     = 1'b1;
        db_timeout = 1'b1;
        if (iniciar) estado_prox = PREPARACAO;
      end
      default: estado_prox = INICIAL;
    endcase
  end

  assign db_estado = estado;

endmodule
